// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers.
// Used by the key scheduler, the S-box and the round datapath.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  localparam int AES128_NR = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OUT  = 1'b1
  } ks_state_t;

  // Multiply by x in GF(2^8) with the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [7:0] r;
    if (b[7]) begin
      r = {b[6:0], 1'b0} ^ 8'h1b;
    end else begin
      r = {b[6:0], 1'b0};
    end
    return r;
  endfunction

  // Rotate a word one byte to the left: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // General GF(2^8) product, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Round constant for the transition from round key idx to idx+1.
  function automatic logic [7:0] rcon_lut(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
// Computes the multiplicative inverse as a^254 with a fixed squaring/multiply
// chain (0 maps to 0 naturally), followed by the AES affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] p2_s, p3_s, p6_s, p7_s, p14_s, p15_s, p30_s, p31_s;
  logic [7:0] p62_s, p63_s, p126_s, p127_s, inv_s;

  assign p2_s   = gf_mul(a, a);
  assign p3_s   = gf_mul(p2_s, a);
  assign p6_s   = gf_mul(p3_s, p3_s);
  assign p7_s   = gf_mul(p6_s, a);
  assign p14_s  = gf_mul(p7_s, p7_s);
  assign p15_s  = gf_mul(p14_s, a);
  assign p30_s  = gf_mul(p15_s, p15_s);
  assign p31_s  = gf_mul(p30_s, a);
  assign p62_s  = gf_mul(p31_s, p31_s);
  assign p63_s  = gf_mul(p62_s, a);
  assign p126_s = gf_mul(p63_s, p63_s);
  assign p127_s = gf_mul(p126_s, a);
  assign inv_s  = gf_mul(p127_s, p127_s);

  // Affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  always_comb begin
    y = inv_s
      ^ {inv_s[6:0], inv_s[7]}
      ^ {inv_s[5:0], inv_s[7:6]}
      ^ {inv_s[4:0], inv_s[7:5]}
      ^ {inv_s[3:0], inv_s[7:4]}
      ^ 8'h63;
  end

endmodule

// File: rtl/aes128_key_sched.sv
// AES-128 on-the-fly key expansion. Emits round keys 0..NR, one per
// accepted valid/ready handshake, with one key per cycle when rk_ready is
// held. Build option KS_RCON_LUT_EN selects the round constant from a lookup
// table indexed by round_idx; otherwise an 8-bit register stepped by xtime
// supplies it. Both builds are externally identical.
module aes128_key_sched
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  if (NR != AES128_NR) begin : g_nr_check
    $error("aes128_key_sched: NR must be 10 for AES-128");
  end

  localparam logic [3:0] LAST_IDX = 4'(NR);

  ks_state_t    state_r, state_nxt_s;
  block_t       round_key_r, key_nxt_s, expand_s;
  logic [3:0]   round_idx_r, idx_nxt_s;
  logic         rk_valid_r, valid_nxt_s;
  logic         busy_r, busy_nxt_s;
  logic         done_r, done_nxt_s;
  logic [7:0]   rcon_s;
  word_t        w0_s, w1_s, w2_s, w3_s;
  word_t        rot_s, sub_s, t_s;
  word_t        n0_s, n1_s, n2_s, n3_s;

  assign w0_s  = round_key_r[127:96];
  assign w1_s  = round_key_r[95:64];
  assign w2_s  = round_key_r[63:32];
  assign w3_s  = round_key_r[31:0];
  assign rot_s = rot_word(w3_s);

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .a (rot_s[8*g +: 8]),
      .y (sub_s[8*g +: 8])
    );
  end

  // Next round key from the current one.
  always_comb begin
    t_s      = sub_s ^ {rcon_s, 24'h000000};
    n0_s     = w0_s ^ t_s;
    n1_s     = w1_s ^ n0_s;
    n2_s     = w2_s ^ n1_s;
    n3_s     = w3_s ^ n2_s;
    expand_s = {n0_s, n1_s, n2_s, n3_s};
  end

`ifdef KS_RCON_LUT_EN
  assign rcon_s = rcon_lut(round_idx_r);
`else
  logic [7:0] rcon_r, rcon_nxt_s;

  assign rcon_s = rcon_r;

  // Round constant: reload on an honoured start, step on each non-final accept.
  always_comb begin
    rcon_nxt_s = rcon_r;
    if (state_r == ST_IDLE) begin
      if (start) begin
        rcon_nxt_s = 8'h01;
      end else begin
        rcon_nxt_s = rcon_r;
      end
    end else begin
      if (rk_ready && (round_idx_r != LAST_IDX)) begin
        rcon_nxt_s = xtime(rcon_r);
      end else begin
        rcon_nxt_s = rcon_r;
      end
    end
  end

  // Round constant register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcon_r <= 8'h01;
    end else begin
      rcon_r <= rcon_nxt_s;
    end
  end
`endif

  // Next-state and next-output decode for the IDLE/OUT sequencer.
  always_comb begin
    state_nxt_s = state_r;
    key_nxt_s   = round_key_r;
    idx_nxt_s   = round_idx_r;
    valid_nxt_s = 1'b0;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_OUT;
          key_nxt_s   = key_in;
          idx_nxt_s   = 4'd0;
          valid_nxt_s = 1'b1;
        end else begin
          valid_nxt_s = 1'b0;
        end
      end
      ST_OUT: begin
        if (rk_ready) begin
          if (round_idx_r == LAST_IDX) begin
            state_nxt_s = ST_IDLE;
            done_nxt_s  = 1'b1;
            valid_nxt_s = 1'b0;
          end else begin
            key_nxt_s   = expand_s;
            idx_nxt_s   = round_idx_r + 4'd1;
            valid_nxt_s = 1'b1;
          end
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        valid_nxt_s = 1'b0;
      end
    endcase
    busy_nxt_s = (state_nxt_s == ST_OUT);
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered outputs and current round key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_key_r <= 128'h0;
      round_idx_r <= 4'd0;
      rk_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      round_key_r <= key_nxt_s;
      round_idx_r <= idx_nxt_s;
      rk_valid_r  <= valid_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  assign rk_valid  = rk_valid_r;
  assign round_key = round_key_r;
  assign round_idx = round_idx_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
